// File: rtl/debug_hex_display.sv
// Purpose: selects one of NUM_CH debug channels (manual or auto-rotate, with freeze) and drives DIGITS active-low 7-seg digits.
// Latency: ch_data -> hex_out 2 cycles, sel -> hex_out 3 cycles; optional leading-zero blanking (DEBUG_HEX_LZ_BLANK_EN) adds none.
// Backpressure: none; free-running display path, freeze holds the displayed value and pauses rotation.
module debug_hex_display #(
    parameter int NUM_CH       = 8,
    parameter int DATA_W       = 16,
    parameter int DWELL_CYCLES = 50000000,
    localparam int DIGITS      = DATA_W / 4,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W       = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    input  logic [CH_W-1:0]            sel,
    input  logic                       auto_en,
    input  logic                       freeze,
    output logic [DIGITS*7-1:0]        hex_out,
    output logic [CH_W-1:0]            cur_ch,
    output logic                       held
);

    localparam logic [CH_W:0]    NUM_CH_V  = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0]     dwell_cnt;
    logic [DATA_W-1:0]    disp_q;
    logic                 freeze_q;
    logic                 freeze_rise;
    logic [DIGITS*7-1:0]  hex_nxt;

    assign freeze_rise = freeze & ~freeze_q;

    // Active-low hex glyphs, segment a in bit 0.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // Freeze edge detect; each rising edge flips the hold state one cycle later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            freeze_q <= 1'b0;
            held     <= 1'b0;
        end else begin
            freeze_q <= freeze;
            held     <= held ^ freeze_rise;
        end
    end

    // Channel index: manual select or dwell-timed rotation; everything parks while held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_ch    <= '0;
            dwell_cnt <= '0;
        end else if (!held) begin
            if (auto_en) begin
                if (dwell_cnt == DWELL_MAX) begin
                    dwell_cnt <= '0;
                    cur_ch    <= (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
                end else begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end
            end else begin
                dwell_cnt <= '0;
                cur_ch    <= ({1'b0, sel} < NUM_CH_V) ? sel : '0;
            end
        end
    end

    // Per-digit glyph selection, with optional blanking of leading zero digits.
    always_comb begin
        logic [3:0] nib;
`ifdef DEBUG_HEX_LZ_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        hex_nxt = '0;
        nib     = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nib = disp_q[d*4 +: 4];
`ifdef DEBUG_HEX_LZ_BLANK_EN
            if (lead && (nib == 4'h0) && (d != 0)) begin
                hex_nxt[d*7 +: 7] = 7'h7F;
            end else begin
                hex_nxt[d*7 +: 7] = seg7(nib);
                lead = 1'b0;
            end
`else
            hex_nxt[d*7 +: 7] = seg7(nib);
`endif
        end
    end

    // Display register captures the selected channel unless frozen; segments registered after it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_q  <= '0;
            hex_out <= {DIGITS{7'h40}};
        end else begin
            if (!held) begin
                disp_q <= ch_data[cur_ch*DATA_W +: DATA_W];
            end
            hex_out <= hex_nxt;
        end
    end

endmodule

// File: tb/tb_debug_hex_display.sv
// Purpose: randomized + directed self-checking bench for debug_hex_display against a behavioural model.
// Latency: model predicts registered outputs edge by edge.
// Backpressure: n/a.
module tb_debug_hex_display;

    localparam int NUM_CH = 5;
    localparam int DATA_W = 16;
    localparam int DWELL  = 4;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_CH*DATA_W-1:0]  ch_data;
    logic [2:0]                sel = 3'd0;
    logic                      auto_en = 1'b0;
    logic                      freeze = 1'b0;
    logic [27:0]               hex_out;
    logic [2:0]                cur_ch;
    logic                      held;

    logic [15:0] chv [NUM_CH];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int          m_cur  = 0;
    int          m_cnt  = 0;
    int          m_held = 0;
    int          m_fq   = 0;
    int          m_disp = 0;
    logic [27:0] m_hex  = 28'h0;

    logic [6:0] seg_tab [16];

    debug_hex_display #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DWELL_CYCLES(DWELL)
    ) dut (
        .clock(clock), .reset(reset), .ch_data(ch_data), .sel(sel),
        .auto_en(auto_en), .freeze(freeze), .hex_out(hex_out),
        .cur_ch(cur_ch), .held(held)
    );

    always #5 clock = ~clock;

    always_comb begin
        ch_data = '0;
        for (int k = 0; k < NUM_CH; k++) ch_data[k*16 +: 16] = chv[k];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected segment word for a value shown on four digits.
    function automatic logic [27:0] expect_hex(input int v);
        logic [27:0] r;
        int top;
        r = '0;
        top = 0;
        for (int d = 0; d < 4; d++) if (((v >> (4*d)) % 16) != 0) top = d;
        for (int d = 0; d < 4; d++) begin
            r[d*7 +: 7] = seg_tab[(v >> (4*d)) % 16];
`ifdef DEBUG_HEX_LZ_BLANK_EN
            if (d > top) r[d*7 +: 7] = 7'h7F;
`endif
        end
        return r;
    endfunction

    function automatic logic [27:0] pack4(input logic [6:0] d3, input logic [6:0] d2,
                                          input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic model_reset();
        m_cur = 0; m_cnt = 0; m_held = 0; m_fq = 0; m_disp = 0;
        m_hex = expect_hex(0);
    endtask

    // One clock edge of the specified behaviour, in terms of the inputs seen at that edge.
    task automatic model_update();
        int rise;
        rise  = (freeze && m_fq == 0) ? 1 : 0;
        m_hex = expect_hex(m_disp);
        if (m_held == 0) begin
            m_disp = int'(chv[m_cur]);
            if (auto_en) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == DWELL) begin
                    m_cnt = 0;
                    m_cur = (m_cur + 1) % NUM_CH;
                end
            end else begin
                m_cnt = 0;
                m_cur = (int'(sel) < NUM_CH) ? int'(sel) : 0;
            end
        end
        m_held = (rise != 0) ? 1 - m_held : m_held;
        m_fq   = freeze ? 1 : 0;
    endtask

    task automatic compare_all();
        check("cur_ch", {29'd0, cur_ch}, m_cur);
        check("held", {31'd0, held}, m_held);
        check("hex_out", {4'd0, hex_out}, {4'd0, m_hex});
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            if (reset) model_reset(); else model_update();
            @(negedge clock);
            compare_all();
        end
    endtask

    task automatic async_reset();
        @(posedge clock);
        model_update();
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("rst_hex_now", {4'd0, hex_out}, 32'h0810_2040);
        check("rst_cur_now", {29'd0, cur_ch}, 32'd0);
        @(negedge clock);
        compare_all();
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] mask;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        chv = '{16'h1234, 16'h00AB, 16'hFFFF, 16'h0000, 16'h8F0E};
        model_reset();
        step(2);
        reset = 1'b0;
        step(2);

        // Reset asserted mid-cycle, then recovery on channel 0.
        async_reset();
        step(3);
        check("ch0_1234", {4'd0, hex_out}, {4'd0, pack4(7'h79, 7'h24, 7'h30, 7'h19)});

        // Manual select and out-of-range select.
        sel = 3'd2;
        step(1);
        check("sel2_cur", {29'd0, cur_ch}, 32'd2);
        step(2);
        check("sel2_hex", {4'd0, hex_out}, {4'd0, pack4(7'h0E, 7'h0E, 7'h0E, 7'h0E)});
        sel = 3'd7;
        step(1);
        check("sel7_cur", {29'd0, cur_ch}, 32'd0);

        // Leading-zero handling.
        sel = 3'd1;
        step(3);
`ifdef DEBUG_HEX_LZ_BLANK_EN
        check("lz_00ab", {4'd0, hex_out}, {4'd0, pack4(7'h7F, 7'h7F, 7'h08, 7'h03)});
`else
        check("lz_00ab", {4'd0, hex_out}, {4'd0, pack4(7'h40, 7'h40, 7'h08, 7'h03)});
`endif
        sel = 3'd3;
        step(3);
`ifdef DEBUG_HEX_LZ_BLANK_EN
        check("lz_0000", {4'd0, hex_out}, {4'd0, pack4(7'h7F, 7'h7F, 7'h7F, 7'h40)});
`else
        check("lz_0000", {4'd0, hex_out}, {4'd0, pack4(7'h40, 7'h40, 7'h40, 7'h40)});
`endif

        // Auto rotate from channel 3, then freeze on channel 4.
        auto_en = 1'b1;
        step(3);
        check("auto_still3", {29'd0, cur_ch}, 32'd3);
        step(1);
        check("auto_to4", {29'd0, cur_ch}, 32'd4);
        freeze = 1'b1;
        step(1);
        freeze = 1'b0;
        check("frz_held", {31'd0, held}, 32'd1);
        step(1);
        check("auto4_hex", {4'd0, hex_out}, {4'd0, pack4(7'h00, 7'h0E, 7'h40, 7'h06)});
        chv[4] = 16'h0001;
        step(22);
        check("frz_hex_kept", {4'd0, hex_out}, {4'd0, pack4(7'h00, 7'h0E, 7'h40, 7'h06)});
        check("frz_cur_kept", {29'd0, cur_ch}, 32'd4);
        freeze = 1'b1;
        step(1);
        freeze = 1'b0;
        check("unfrz_held", {31'd0, held}, 32'd0);
        step(2);
        check("resume_still4", {29'd0, cur_ch}, 32'd4);
        step(1);
        check("resume_to0", {29'd0, cur_ch}, 32'd0);
        step(4);
        check("auto_to1", {29'd0, cur_ch}, 32'd1);

        // Freeze held high for many cycles toggles once.
        freeze = 1'b1;
        step(10);
        check("lvl_one_toggle", {31'd0, held}, 32'd1);
        freeze = 1'b0;
        step(3);
        check("lvl_still_held", {31'd0, held}, 32'd1);
        freeze = 1'b1;
        step(1);
        freeze = 1'b0;
        step(1);
        check("lvl_released", {31'd0, held}, 32'd0);
        auto_en = 1'b0;

        // Randomized traffic, model-checked every cycle.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 40) == 0) auto_en = ~auto_en;
            freeze = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) == 0) begin
                mask = 16'hFFFF >> (4 * $urandom_range(0, 4));
                chv[$urandom_range(0, NUM_CH - 1)] = 16'($urandom) & mask;
            end
            if ($urandom_range(0, 300) == 0) async_reset();
            else step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
